// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [63:0] NOPINSTR       = '0;
    localparam int          PCPLUS8_OFFSET = 8;

endpackage

// File: rtl/instruction_skid_buffer.sv
// One-entry holding slot for a fetched word that arrives while Decode is stalled.
module instruction_skid_buffer #(
    parameter int WIDTH            = 8,
    parameter int INSTRUCTIONWIDTH = 24
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        unload,
    input  logic                        clear,
    input  logic [INSTRUCTIONWIDTH-1:0] loadInstruction,
    input  logic [WIDTH-1:0]            loadPCPlus8,
    output logic [INSTRUCTIONWIDTH-1:0] skidInstruction,
    output logic [WIDTH-1:0]            skidPCPlus8,
    output logic                        full
);

    // Clear (branch squash) wins over load so a squashed word never lingers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full            <= 1'b0;
            skidInstruction <= '0;
            skidPCPlus8     <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full            <= 1'b1;
            skidInstruction <= loadInstruction;
            skidPCPlus8     <= loadPCPlus8;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, runs the instruction-memory handshake and feeds Decode,
// absorbing back-pressure with a skid entry and squashing stale fetches on redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int RESETPC          = 0,
    parameter int PCINC            = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        branchTaken,
    input  logic [WIDTH-1:0]            branchTarget,
    input  logic                        imemReady,
    input  logic [INSTRUCTIONWIDTH-1:0] imemData,
    output logic                        imemRequest,
    output logic [WIDTH-1:0]            imemAddress,
    output logic [INSTRUCTIONWIDTH-1:0] instruction,
    output logic [WIDTH-1:0]            PCPlus8,
    output logic                        instrValid
);

    fetch_state_t                  state, stateNext;
    logic [WIDTH-1:0]              pc, pcNext;
    logic [WIDTH-1:0]              drainAddress, drainAddressNext;
    logic                          requestEnable;
    logic [INSTRUCTIONWIDTH-1:0]   instructionNext;
    logic [WIDTH-1:0]              pcPlus8Next;
    logic                          instrValidNext;
    logic                          skidLoad, skidUnload, skidClear, skidFull;
    logic [INSTRUCTIONWIDTH-1:0]   skidInstruction;
    logic [WIDTH-1:0]              skidPCPlus8;
    logic                          slotFree, fetchDone;
    logic [WIDTH-1:0]              wordPCPlus8;

    // requestEnable keeps the request low for the first cycle after reset release.
    assign imemRequest = requestEnable && (state != HOLD);
    assign imemAddress = (state == DRAIN) ? drainAddress : pc;
    assign slotFree    = !instrValid || !stall;
    assign fetchDone   = imemRequest && imemReady;
    assign wordPCPlus8 = pc + WIDTH'(PCPLUS8_OFFSET);

    instruction_skid_buffer #(
        .WIDTH            (WIDTH),
        .INSTRUCTIONWIDTH (INSTRUCTIONWIDTH)
    ) skid (
        .clock           (clock),
        .reset           (reset),
        .load            (skidLoad),
        .unload          (skidUnload),
        .clear           (skidClear),
        .loadInstruction (imemData),
        .loadPCPlus8     (wordPCPlus8),
        .skidInstruction (skidInstruction),
        .skidPCPlus8     (skidPCPlus8),
        .full            (skidFull)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= FETCH;
            pc            <= WIDTH'(RESETPC);
            drainAddress  <= '0;
            requestEnable <= 1'b0;
            instruction   <= NOPINSTR[INSTRUCTIONWIDTH-1:0];
            PCPlus8       <= '0;
            instrValid    <= 1'b0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            drainAddress  <= drainAddressNext;
            requestEnable <= 1'b1;
            instruction   <= instructionNext;
            PCPlus8       <= pcPlus8Next;
            instrValid    <= instrValidNext;
        end
    end

    always_comb begin
        stateNext        = state;
        pcNext           = pc;
        drainAddressNext = drainAddress;
        instructionNext  = instruction;
        pcPlus8Next      = PCPlus8;
        instrValidNext   = instrValid;
        skidLoad         = 1'b0;
        skidUnload       = 1'b0;
        skidClear        = 1'b0;

        if (branchTaken) begin
            pcNext          = branchTarget;
            instrValidNext  = 1'b0;
            instructionNext = NOPINSTR[INSTRUCTIONWIDTH-1:0];
            skidClear       = 1'b1;
            unique case (state)
                FETCH: begin
                    // An unanswered request must still be completed before redirecting.
                    if (imemRequest && !imemReady) begin
                        stateNext        = DRAIN;
                        drainAddressNext = pc;
                    end
                end
                HOLD:    stateNext = FETCH;
                DRAIN:   stateNext = imemReady ? FETCH : DRAIN;
                default: stateNext = FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (fetchDone) begin
                        pcNext = pc + WIDTH'(PCINC);
                        if (slotFree) begin
                            instructionNext = imemData;
                            pcPlus8Next     = wordPCPlus8;
                            instrValidNext  = 1'b1;
                        end else begin
                            skidLoad  = 1'b1;
                            stateNext = HOLD;
                        end
                    end else if (instrValid && !stall) begin
                        instrValidNext = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instructionNext = skidInstruction;
                        pcPlus8Next     = skidPCPlus8;
                        instrValidNext  = skidFull;
                        skidUnload      = 1'b1;
                        stateNext       = FETCH;
                    end
                end
                DRAIN: begin
                    if (instrValid && !stall) begin
                        instrValidNext = 1'b0;
                    end
                    if (imemReady) begin
                        stateNext = FETCH;
                    end
                end
                default: stateNext = FETCH;
            endcase
        end
    end

endmodule
